mic1_mem_ctrl: RTL and testbench

//  Memory controller between the mic1 datapath and a single-port, word-addressed, variable-latency memory bus.

---
 rtl/mic1_mem_ctrl.sv | 254 +++++++++++++++++++++++++
 tb/tb_mic1_mem_ctrl.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mic1_mem_ctrl.sv
// mic1_mem_ctrl: mic1 datapath <-> single-port word-addressed memory bus, with a 1-word fetch buffer.
// Latency: a fetch-buffer hit updates cpu_instr at the next edge. With immediate gnt/rvalid, a bus
// access returns on the 3rd edge after acceptance, or the 5th when a read is followed by a fetch miss.
// Backpressure: cpu_stall is high while the bus is busy. bus_req holds with stable addr/data until
// bus_gnt. A stuck access is abandoned after MAX_WAIT cycles in one state, and cpu_err pulses.
//
// Ports:
//   clk, reset             clock and synchronous active-high reset
//   cpu_addr/cpu_wdata     data word address (MAR) and write data (MDR)
//   cpu_read/write/fetch   CPU strobes, sampled only in IDLE
//   cpu_pc                 fetch byte address
//   cpu_rdata/cpu_instr    last read word / last fetched byte
//   cpu_stall/cpu_err      hold request / one-cycle error pulse
//   bus_*                  request/grant memory bus with separate read-data valid

module mic1_mem_ctrl #(
  parameter int ADDR_W   = 32,
  parameter bit FBUF_EN  = 1'b1,
  parameter int MAX_WAIT = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [31:0]       cpu_addr,
  input  logic [31:0]       cpu_wdata,
  input  logic              cpu_read,
  input  logic              cpu_write,
  input  logic              cpu_fetch,
  input  logic [31:0]       cpu_pc,
  output logic [31:0]       cpu_rdata,
  output logic [7:0]        cpu_instr,
  output logic              cpu_stall,
  output logic              cpu_err,
  output logic              bus_req,
  output logic              bus_we,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [31:0]       bus_wdata,
  input  logic              bus_gnt,
  input  logic              bus_rvalid,
  input  logic [31:0]       bus_rdata
);

  localparam int CNT_W = $clog2(MAX_WAIT + 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    D_REQ  = 3'd1,
    D_WAIT = 3'd2,
    F_REQ  = 3'd3,
    F_WAIT = 3'd4
  } state_t;

  state_t state_q, state_d;

  // Latched request
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic [ADDR_W-1:0] fword_q;
  logic [1:0]        lane_q;
  logic              pend_we;
  logic              pend_fetch;

  // Fetch buffer
  logic              fbuf_vld;
  logic [ADDR_W-1:0] fbuf_tag;
  logic [31:0]       fbuf_dat;

  logic [CNT_W-1:0]  tmo_cnt;

  logic [ADDR_W-1:0] addr_in;
  logic [ADDR_W-1:0] fword_in;
  logic              data_in;
  logic              hit_in;
  logic              wr_inval;
  logic              pend_hit;
  logic              tmo_reached;
  logic              timeout;

  // Size casts truncate or zero-extend, so any ADDR_W works.
  assign addr_in  = ADDR_W'(cpu_addr);
  assign fword_in = ADDR_W'(cpu_pc[31:2]);
  assign data_in  = cpu_read | cpu_write;
  assign hit_in   = FBUF_EN && fbuf_vld && (fbuf_tag == fword_in);

  // A granted write to the buffered word kills the buffer on the same edge.
  // So a fetch queued behind that write must not be treated as a hit.
  assign wr_inval = (state_q == D_REQ) && bus_gnt && pend_we && fbuf_vld && (addr_q == fbuf_tag);
  assign pend_hit = FBUF_EN && fbuf_vld && !wr_inval && (fbuf_tag == fword_q);

  assign tmo_reached = (tmo_cnt == CNT_W'(MAX_WAIT - 1));

  // Big-endian byte lane: pc[1:0]=0 selects the most significant byte.
  function automatic logic [7:0] sel_byte(input logic [31:0] w, input logic [1:0] lane);
    logic [7:0] b;
    case (lane)
      2'd0:    b = w[31:24];
      2'd1:    b = w[23:16];
      2'd2:    b = w[15:8];
      default: b = w[7:0];
    endcase
    return b;
  endfunction

  // State register and per-state timeout counter
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      tmo_cnt <= '0;
    end else begin
      state_q <= state_d;
      if (state_d != state_q || state_q == IDLE) tmo_cnt <= '0;
      else                                        tmo_cnt <= tmo_cnt + CNT_W'(1);
    end
  end

  // Next state and bus/stall outputs
  always_comb begin
    state_d   = state_q;
    bus_req   = 1'b0;
    bus_we    = 1'b0;
    bus_addr  = '0;
    bus_wdata = '0;
    cpu_stall = 1'b0;
    timeout   = 1'b0;
    case (state_q)
      IDLE: begin
        if (data_in) begin
          cpu_stall = 1'b1;
          state_d   = D_REQ;
        end else if (cpu_fetch && !hit_in) begin
          cpu_stall = 1'b1;
          state_d   = F_REQ;
        end
      end
      D_REQ: begin
        cpu_stall = 1'b1;
        bus_req   = 1'b1;
        bus_we    = pend_we;
        bus_addr  = addr_q;
        bus_wdata = pend_we ? wdata_q : 32'd0;
        if (bus_gnt) begin
          if (!pend_we)                    state_d = D_WAIT;
          else if (pend_fetch && !pend_hit) state_d = F_REQ;
          else                             state_d = IDLE;
        end else if (tmo_reached) begin
          timeout = 1'b1;
          state_d = IDLE;
        end
      end
      D_WAIT: begin
        cpu_stall = 1'b1;
        if (bus_rvalid) begin
          state_d = (pend_fetch && !pend_hit) ? F_REQ : IDLE;
        end else if (tmo_reached) begin
          timeout = 1'b1;
          state_d = IDLE;
        end
      end
      F_REQ: begin
        cpu_stall = 1'b1;
        bus_req   = 1'b1;
        bus_addr  = fword_q;
        if (bus_gnt) begin
          state_d = F_WAIT;
        end else if (tmo_reached) begin
          timeout = 1'b1;
          state_d = IDLE;
        end
      end
      F_WAIT: begin
        cpu_stall = 1'b1;
        if (bus_rvalid) begin
          state_d = IDLE;
        end else if (tmo_reached) begin
          timeout = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Request latch, fetch buffer and CPU-facing result registers
  always_ff @(posedge clk) begin
    if (reset) begin
      addr_q     <= '0;
      wdata_q    <= '0;
      fword_q    <= '0;
      lane_q     <= '0;
      pend_we    <= 1'b0;
      pend_fetch <= 1'b0;
      fbuf_vld   <= 1'b0;
      fbuf_tag   <= '0;
      fbuf_dat   <= '0;
      cpu_rdata  <= '0;
      cpu_instr  <= '0;
      cpu_err    <= 1'b0;
    end else begin
      cpu_err <= 1'b0;
      case (state_q)
        IDLE: begin
          if (data_in || cpu_fetch) begin
            addr_q     <= addr_in;
            wdata_q    <= cpu_wdata;
            fword_q    <= fword_in;
            lane_q     <= cpu_pc[1:0];
            pend_we    <= cpu_write;   // write wins over a simultaneous read
            pend_fetch <= cpu_fetch;
            if (cpu_read && cpu_write) cpu_err <= 1'b1;
            if (cpu_fetch && !data_in && hit_in) begin
              cpu_instr  <= sel_byte(fbuf_dat, cpu_pc[1:0]);
              pend_fetch <= 1'b0;
            end
          end
        end
        D_REQ: begin
          if (bus_gnt && pend_we) begin
            if (wr_inval) fbuf_vld <= 1'b0;
            if (pend_fetch && pend_hit) begin
              cpu_instr  <= sel_byte(fbuf_dat, lane_q);
              pend_fetch <= 1'b0;
            end
          end
        end
        D_WAIT: begin
          if (bus_rvalid) begin
            cpu_rdata <= bus_rdata;
            if (pend_fetch && pend_hit) begin
              cpu_instr  <= sel_byte(fbuf_dat, lane_q);
              pend_fetch <= 1'b0;
            end
          end
        end
        F_WAIT: begin
          if (bus_rvalid) begin
            fbuf_vld   <= FBUF_EN;
            fbuf_tag   <= fword_q;
            fbuf_dat   <= bus_rdata;
            cpu_instr  <= sel_byte(bus_rdata, lane_q);
            pend_fetch <= 1'b0;
          end
        end
        default: ;
      endcase
      // An abandoned access leaves rdata/instr alone but cannot trust the buffer.
      if (timeout) begin
        cpu_err    <= 1'b1;
        pend_we    <= 1'b0;
        pend_fetch <= 1'b0;
        fbuf_vld   <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mic1_mem_ctrl.sv
module tb_mic1_mem_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] cpu_addr = '0, cpu_wdata = '0, cpu_pc = '0;
  logic        cpu_read = 1'b0, cpu_write = 1'b0, cpu_fetch = 1'b0;
  logic [31:0] cpu_rdata;
  logic [7:0]  cpu_instr;
  logic        cpu_stall, cpu_err;
  logic        bus_req, bus_we, bus_gnt;
  logic [31:0] bus_addr, bus_wdata;
  logic        bus_rvalid;
  logic [31:0] bus_rdata = '0;

  int checks = 0;
  int failures = 0;

  // Bus responder state
  bit          gnt_en = 1'b1;
  int          rv_delay = 1;
  logic        rv_drv = 1'b0;
  bit          rv_busy = 1'b0;
  int          rv_left = 0;
  logic [31:0] rv_word = '0;
  int          rv_total = 0;
  logic        last_we = 1'b0;
  logic [31:0] mem [256];
  logic [31:0] rd_log [$];
  int          err_cnt = 0;

  logic [31:0] exp_q [$];

  always #5 clk = ~clk;

  assign bus_gnt    = bus_req & gnt_en;
  assign bus_rvalid = rv_drv;

  mic1_mem_ctrl dut (
    .clk(clk), .reset(reset),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_read(cpu_read), .cpu_write(cpu_write), .cpu_fetch(cpu_fetch),
    .cpu_pc(cpu_pc),
    .cpu_rdata(cpu_rdata), .cpu_instr(cpu_instr),
    .cpu_stall(cpu_stall), .cpu_err(cpu_err),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .bus_gnt(bus_gnt), .bus_rvalid(bus_rvalid), .bus_rdata(bus_rdata)
  );

  // Memory model: accepts at grant, returns read data rv_delay cycles after the grant cycle.
  always @(negedge clk) begin
    rv_drv = 1'b0;
    if (rv_busy) begin
      rv_left = rv_left - 1;
      if (rv_left == 0) begin
        rv_drv    = 1'b1;
        bus_rdata = rv_word;
        rv_busy   = 1'b0;
        rv_total  = rv_total + 1;
      end
    end
    if (bus_req && bus_gnt) begin
      last_we = bus_we;
      if (bus_we) begin
        mem[bus_addr[7:0]] = bus_wdata;
      end else begin
        rd_log.push_back(bus_addr);
        rv_busy = 1'b1;
        rv_left = rv_delay;
        rv_word = mem[bus_addr[7:0]];
      end
    end
  end

  always @(posedge clk) if (cpu_err) err_cnt <= err_cnt + 1;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Present strobes for one accepted cycle and count stall cycles from the strobe cycle on.
  task automatic do_op(input logic r, input logic w, input logic f,
                       input logic [31:0] a, input logic [31:0] d, input logic [31:0] pc,
                       output int sc);
    bit done;
    @(posedge clk); #1;
    cpu_read = r; cpu_write = w; cpu_fetch = f;
    cpu_addr = a; cpu_wdata = d; cpu_pc = pc;
    @(negedge clk);
    sc = cpu_stall ? 1 : 0;
    @(posedge clk); #1;
    cpu_read = 1'b0; cpu_write = 1'b0; cpu_fetch = 1'b0;
    done = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (!cpu_stall) begin
        done = 1'b1;
        break;
      end
      sc++;
    end
    chk("op_completes", 32'(done), 32'd1);
  endtask

  initial begin
    int sc;
    int e0;
    int r0;
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    mem[5]  = 32'h11223344;
    mem[3]  = 32'h55667788;
    mem[16] = 32'hA1B2C3D4;

    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rst_rdata", cpu_rdata, 32'd0);
    chk("rst_instr", 32'(cpu_instr), 32'd0);
    chk("rst_stall", 32'(cpu_stall), 32'd0);
    chk("rst_err",   32'(cpu_err), 32'd0);
    chk("rst_req",   32'(bus_req), 32'd0);
    chk("rst_we",    32'(bus_we), 32'd0);
    chk("rst_addr",  bus_addr, 32'd0);
    chk("rst_wdata", bus_wdata, 32'd0);

    // 1. Plain read, data two cycles after the grant cycle
    rv_delay = 2;
    exp_q.push_back(32'hDEADBEEF);
    mem[16] = 32'hDEADBEEF;
    do_op(1'b1, 1'b0, 1'b0, 32'h10, 32'h0, 32'h0, sc);
    chk("t1_rdata", cpu_rdata, exp_q.pop_front());
    chk("t1_stall_cycles", 32'(sc), 32'd4);
    mem[16] = 32'hA1B2C3D4;
    rv_delay = 1;

    // 2. Fetch sweep over word 5: one refill then three hits
    rd_log.delete();
    exp_q.push_back(32'h11); exp_q.push_back(32'h22);
    exp_q.push_back(32'h33); exp_q.push_back(32'h44);
    for (int p = 20; p < 24; p++) begin
      do_op(1'b0, 1'b0, 1'b1, 32'h0, 32'h0, 32'(p), sc);
      chk("t2_instr", 32'(cpu_instr), exp_q.pop_front());
      chk("t2_stall_cycles", 32'(sc), (p == 20) ? 32'd3 : 32'd0);
    end
    chk("t2_bus_reads", 32'(rd_log.size()), 32'd1);

    // 3. Read plus fetch miss in one cycle: data access first, then the fetch
    rd_log.delete();
    exp_q.push_back(32'h55667788); exp_q.push_back(32'hA1);
    do_op(1'b1, 1'b0, 1'b1, 32'h3, 32'h0, 32'h40, sc);
    chk("t3_rdata", cpu_rdata, exp_q.pop_front());
    chk("t3_instr", 32'(cpu_instr), exp_q.pop_front());
    chk("t3_stall_cycles", 32'(sc), 32'd5);
    chk("t3_bus_reads", 32'(rd_log.size()), 32'd2);
    if (rd_log.size() == 2) begin
      chk("t3_first_addr", rd_log[0], 32'd3);
      chk("t3_second_addr", rd_log[1], 32'd16);
    end

    // 4. Write to the buffered word invalidates it
    do_op(1'b0, 1'b0, 1'b1, 32'h0, 32'h0, 32'd20, sc);
    chk("t4_refill_instr", 32'(cpu_instr), 32'h11);
    do_op(1'b0, 1'b1, 1'b0, 32'h5, 32'hCAFEF00D, 32'h0, sc);
    chk("t4_write_we", 32'(last_we), 32'd1);
    chk("t4_write_mem", mem[5], 32'hCAFEF00D);
    chk("t4_write_stall_cycles", 32'(sc), 32'd2);
    rd_log.delete();
    exp_q.push_back(32'hCA);
    do_op(1'b0, 1'b0, 1'b1, 32'h0, 32'h0, 32'd20, sc);
    chk("t4_refetch_instr", 32'(cpu_instr), exp_q.pop_front());
    chk("t4_refetch_stall", 32'(sc), 32'd3);
    chk("t4_refetch_reads", 32'(rd_log.size()), 32'd1);
    do_op(1'b0, 1'b0, 1'b1, 32'h0, 32'h0, 32'd21, sc);
    chk("t4_hit_instr", 32'(cpu_instr), 32'hFE);
    chk("t4_hit_stall", 32'(sc), 32'd0);

    // 5. Grant withheld: timeout after MAX_WAIT cycles in D_REQ
    gnt_en = 1'b0;
    e0 = err_cnt;
    do_op(1'b1, 1'b0, 1'b0, 32'h7, 32'h0, 32'h0, sc);
    @(negedge clk);
    chk("t5_stall_cycles", 32'(sc), 32'd256);
    chk("t5_err_pulse", 32'(err_cnt - e0), 32'd1);
    chk("t5_rdata_kept", cpu_rdata, 32'h55667788);
    chk("t5_instr_kept", 32'(cpu_instr), 32'hFE);
    repeat (40) @(negedge clk);
    chk("t5_idle_stall", 32'(cpu_stall), 32'd0);
    chk("t5_idle_req", 32'(bus_req), 32'd0);
    gnt_en = 1'b1;
    do_op(1'b0, 1'b0, 1'b1, 32'h0, 32'h0, 32'd21, sc);
    chk("t5_buf_invalid", 32'(sc), 32'd3);
    chk("t5_fetch_instr", 32'(cpu_instr), 32'hFE);

    // 5b. Read and write together: write only, error pulse
    rd_log.delete();
    e0 = err_cnt;
    do_op(1'b1, 1'b1, 1'b0, 32'h9, 32'h12345678, 32'h0, sc);
    @(negedge clk);
    chk("t5b_mem", mem[9], 32'h12345678);
    chk("t5b_err_pulse", 32'(err_cnt - e0), 32'd1);
    chk("t5b_no_read", 32'(rd_log.size()), 32'd0);
    chk("t5b_stall_cycles", 32'(sc), 32'd2);
    chk("t5b_rdata_kept", cpu_rdata, 32'h55667788);

    // 6. Reset in D_WAIT, read data arrives afterwards
    rv_delay = 6;
    r0 = rv_total;
    @(posedge clk); #1;
    cpu_read = 1'b1; cpu_addr = 32'h10;
    @(posedge clk); #1;
    cpu_read = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("t6_req", 32'(bus_req), 32'd0);
    chk("t6_stall", 32'(cpu_stall), 32'd0);
    chk("t6_rdata", cpu_rdata, 32'd0);
    chk("t6_instr", 32'(cpu_instr), 32'd0);
    repeat (8) @(negedge clk);
    chk("t6_late_rvalid_seen", 32'(rv_total - r0), 32'd1);
    chk("t6_rdata_after_rvalid", cpu_rdata, 32'd0);
    chk("t6_stall_after_rvalid", 32'(cpu_stall), 32'd0);
    rv_delay = 1;
    do_op(1'b0, 1'b0, 1'b1, 32'h0, 32'h0, 32'd20, sc);
    chk("t6_buf_invalid", 32'(sc), 32'd3);
    chk("t6_fetch_instr", 32'(cpu_instr), 32'hCA);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
